// File: rtl/pacman_move_ctrl.sv
// pacman_move_ctrl: per-sprite movement sequencer that queries the collision detector and steps Pacman.
module pacman_move_ctrl #(
  parameter logic [8:0] X_INIT = 9'd0,
  parameter logic [8:0] Y_INIT = 9'd0,
  parameter logic [8:0] X_MAX = 9'd319,
  parameter logic [8:0] Y_MAX = 9'd239,
  parameter logic [8:0] STEP = 9'd1,
  parameter int CHK_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_dir,
  input  logic       move_tick,
  input  logic       chk_collide,
  output logic [8:0] chk_x,
  output logic [8:0] chk_y,
  output logic [3:0] chk_dir,
  output logic [8:0] p_x,
  output logic [8:0] p_y,
  output logic [3:0] cur_dir,
  output logic       busy,
  output logic       moved,
  output logic       tick_miss
);
  localparam int CW = $clog2(CHK_LAT + 2);
  typedef enum logic [1:0] {IDLE, CHK_NEW, CHK_CUR, STEP_S} state_t;
  state_t state, state_n;
  logic [3:0] want_dir, idle_want;
  logic [CW-1:0] cnt;
  logic key_ok, done, checking;
  logic [9:0] x10, y10, s10, nx_l, nx_r, ny_u, ny_d;
  assign key_ok = key_valid && $onehot(key_dir);
  assign done = cnt == CW'(CHK_LAT);
  assign checking = state == CHK_NEW || state == CHK_CUR;
  assign idle_want = key_ok ? key_dir : want_dir;
  assign busy = state != IDLE;
  assign chk_x = p_x;
  assign chk_y = p_y;
  assign x10 = {1'b0, p_x};
  assign y10 = {1'b0, p_y};
  assign s10 = {1'b0, STEP};
  // 10-bit intermediates keep the wrap compare correct even when X_MAX+STEP exceeds 9 bits
  assign nx_l = x10 < s10 ? x10 + {1'b0, X_MAX} + 10'd1 - s10 : x10 - s10;
  assign nx_r = x10 + s10 > {1'b0, X_MAX} ? x10 + s10 - {1'b0, X_MAX} - 10'd1 : x10 + s10;
  assign ny_u = y10 < s10 ? y10 + {1'b0, Y_MAX} + 10'd1 - s10 : y10 - s10;
  assign ny_d = y10 + s10 > {1'b0, Y_MAX} ? y10 + s10 - {1'b0, Y_MAX} - 10'd1 : y10 + s10;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !move_tick ? IDLE : idle_want != 4'd0 ? CHK_NEW : cur_dir != 4'd0 ? CHK_CUR : IDLE;
      CHK_NEW: state_n = !done ? CHK_NEW : !chk_collide ? STEP_S : cur_dir != 4'd0 ? CHK_CUR : IDLE;
      CHK_CUR: state_n = !done ? CHK_CUR : chk_collide ? IDLE : STEP_S;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      want_dir <= 4'd0;
      cur_dir <= 4'd0;
      chk_dir <= 4'd0;
      p_x <= X_INIT;
      p_y <= Y_INIT;
      moved <= 1'b0;
      tick_miss <= 1'b0;
    end else begin
      state <= state_n;
      moved <= 1'b0;
      tick_miss <= move_tick && busy;
      cnt <= checking && !done ? cnt + 1'b1 : '0;
      if (key_ok) want_dir <= key_dir;
      if (state == IDLE && state_n != IDLE) chk_dir <= idle_want != 4'd0 ? idle_want : cur_dir;
      if (state == CHK_NEW && done && !chk_collide) begin
        cur_dir <= chk_dir;
        if (!key_ok) want_dir <= 4'd0;
      end
      if (state == CHK_NEW && done && chk_collide && cur_dir != 4'd0) chk_dir <= cur_dir;
      if (state == CHK_CUR && done && chk_collide) cur_dir <= 4'd0;
      if (state == STEP_S) begin
        p_x <= cur_dir[3] ? nx_l[8:0] : cur_dir[1] ? nx_r[8:0] : p_x;
        p_y <= cur_dir[2] ? ny_u[8:0] : cur_dir[0] ? ny_d[8:0] : p_y;
        moved <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pacman_move_ctrl.sv
// tb_pacman_move_ctrl: directed vectors with hand-computed expectations for pacman_move_ctrl.
module tb_pacman_move_ctrl;
  logic clk = 0, rst = 1, key_valid = 0, move_tick = 0, chk_collide = 0;
  logic [3:0] key_dir = 0, chk_dir, cur_dir;
  logic [8:0] chk_x, chk_y, p_x, p_y;
  logic busy, moved, tick_miss;
  int total = 0, passed = 0;
  localparam logic [3:0] L = 4'b1000, U = 4'b0100, R = 4'b0010, D = 4'b0001;
  pacman_move_ctrl #(.X_INIT(9'd100), .Y_INIT(9'd50)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_dir(key_dir), .move_tick(move_tick),
    .chk_collide(chk_collide), .chk_x(chk_x), .chk_y(chk_y), .chk_dir(chk_dir), .p_x(p_x),
    .p_y(p_y), .cur_dir(cur_dir), .busy(busy), .moved(moved), .tick_miss(tick_miss)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    move_tick = 0;
    key_valid = 0;
  endtask
  task automatic key(input logic [3:0] d);
    key_valid = 1;
    key_dir = d;
  endtask
  task automatic move();
    move_tick = 1;
    repeat (5) cyc();
  endtask
  initial begin
    repeat (3) cyc();
    rst = 0;
    cyc();
    check("rst_px", p_x, 100);
    check("rst_py", p_y, 50);
    check("rst_dir", cur_dir, 0);
    check("rst_chkdir", chk_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_moved", moved, 0);
    check("rst_miss", tick_miss, 0);
    key(L); move_tick = 1;
    cyc(); cyc();
    check("mid_busy", busy, 1);
    rst = 1; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dir", cur_dir, 0);
    cyc(); rst = 0;
    move_tick = 1;
    cyc();
    check("no_want_idle", busy, 0);
    check("no_want_chkdir", chk_dir, 0);
    key(L); move_tick = 1;
    cyc();
    check("turn_chkdir1", chk_dir, L);
    check("turn_busy", busy, 1);
    cyc(); cyc();
    check("turn_chkdir3", chk_dir, L);
    cyc();
    check("turn_px4", p_x, 100);
    check("turn_moved4", moved, 0);
    cyc();
    check("turn_px5", p_x, 99);
    check("turn_dir5", cur_dir, L);
    check("turn_moved5", moved, 1);
    check("turn_busy5", busy, 0);
    check("turn_chkx", chk_x, 99);
    cyc();
    check("turn_moved6", moved, 0);
    key(R); move();
    check("r_px", p_x, 100);
    check("r_dir", cur_dir, R);
    key(U); move_tick = 1; chk_collide = 1;
    cyc();
    check("blk_chkdir1", chk_dir, U);
    cyc(); cyc(); cyc();
    chk_collide = 0;
    check("blk_chkdir4", chk_dir, R);
    check("blk_dir4", cur_dir, R);
    cyc(); cyc(); cyc();
    check("blk_moved7", moved, 0);
    cyc();
    check("blk_px8", p_x, 101);
    check("blk_py8", p_y, 50);
    check("blk_moved8", moved, 1);
    move_tick = 1;
    cyc();
    check("want_kept", chk_dir, U);
    repeat (4) cyc();
    check("want_py", p_y, 49);
    check("want_dir", cur_dir, U);
    key(D); move();
    check("d_py", p_y, 50);
    move_tick = 1; chk_collide = 1;
    cyc();
    check("stop_chkdir", chk_dir, D);
    cyc(); cyc(); cyc();
    chk_collide = 0;
    check("stop_dir", cur_dir, 0);
    check("stop_busy", busy, 0);
    check("stop_py", p_y, 50);
    check("stop_moved", moved, 0);
    key(L); cyc();
    repeat (101) move();
    check("wrap_x0", p_x, 0);
    move();
    check("wrap_l", p_x, 319);
    key(R); cyc();
    move();
    check("wrap_r", p_x, 0);
    move();
    check("wrap_r1", p_x, 1);
    key(U); cyc();
    repeat (50) move();
    check("wrap_y0", p_y, 0);
    move();
    check("wrap_u", p_y, 239);
    key(D); cyc();
    move();
    check("wrap_d", p_y, 0);
    key(D); move_tick = 1;
    cyc(); cyc();
    move_tick = 1;
    cyc();
    check("miss_pulse", tick_miss, 1);
    key(L);
    cyc();
    check("miss_clear", tick_miss, 0);
    cyc();
    check("miss_py", p_y, 1);
    check("miss_moved", moved, 1);
    check("miss_dir", cur_dir, D);
    key(4'b0011);
    cyc(); cyc(); cyc();
    check("miss_one_step", p_y, 1);
    check("miss_idle", busy, 0);
    move_tick = 1;
    cyc();
    check("late_key", chk_dir, L);
    repeat (4) cyc();
    check("late_px", p_x, 0);
    check("late_dir", cur_dir, L);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
